// File: rtl/fir_xifu_pkg.sv
// Shared types for the FIR XIFU pipeline: instruction encodings, inter-stage
// payloads and the execute-stage memory request format.
package fir_xifu_pkg;

  localparam int unsigned X_ID_WIDTH = 4;
  localparam int unsigned NB_IDS     = 16;

  typedef enum logic [2:0] {
    INSTR_INVALID  = 3'd0,
    INSTR_XFIRLW   = 3'd1,
    INSTR_XFIRSW   = 3'd2,
    INSTR_XFIRDOTP = 3'd3
  } instr_e;

  typedef enum logic [1:0] {
    EX_IDLE = 2'd0,
    EX_REQ  = 2'd1,
    EX_DONE = 2'd2
  } ex_state_e;

  typedef struct packed {
    logic                  valid;
    logic [X_ID_WIDTH-1:0] id;
    instr_e                instr;
    logic [4:0]            rd;
    logic [31:0]           rs1_cv;
    logic [4:0]            rs1_addr;
    logic [11:0]           imm;
    logic [31:0]           op_a;
    logic [31:0]           op_b;
    logic [31:0]           acc;
  } id2ex_t;

  typedef struct packed {
    logic [NB_IDS-1:0] kill;
  } ctrl2ex_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    instr_e                instr;
    logic [4:0]            rd;
    logic [31:0]           result;
    logic [31:0]           next_addr;
  } ex2wb_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] result;
    logic        we;
  } wb_fwd_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [31:0]           addr;
    logic [1:0]            mode;
    logic                  we;
    logic [2:0]            size;
    logic [3:0]            be;
    logic [1:0]            attr;
    logic [31:0]           wdata;
  } xif_mem_req_t;

  localparam ex2wb_t EX2WB_BUBBLE = '{
    id: '0, instr: INSTR_INVALID, rd: 5'd0, result: 32'd0, next_addr: 32'd0
  };

  function automatic logic [31:0] sext_imm(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/fir_xifu_ex_if.sv
// CV32E40X eXtension interface, memory request channel only: the coprocessor
// issues mem_valid/mem_req and the core answers with mem_ready.
interface cv32e40x_if_xif;
  import fir_xifu_pkg::*;

  logic         mem_valid;
  logic         mem_ready;
  xif_mem_req_t mem_req;

  modport coproc_mem (output mem_valid, output mem_req, input mem_ready);
  modport core_mem   (input mem_valid, input mem_req, output mem_ready);
  modport master     (output mem_valid, output mem_req, input mem_ready);
  modport slave      (input mem_valid, input mem_req, output mem_ready);

endinterface

// File: rtl/fir_xifu_ex_dotp.sv
// Packed 16-bit signed lane multiply-accumulate for XFIRDOTP; purely
// combinational so the execute stage completes it in the accept cycle.
module fir_xifu_dotp #(
  parameter int unsigned NB_LANES   = 2,
  parameter int unsigned DOTP_SHIFT = 0
) (
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] acc,
  output logic [31:0] result
);

  logic signed [15:0] lane_a_s;
  logic signed [15:0] lane_b_s;
  logic signed [31:0] prod_s;
  logic signed [32:0] sum_s;
  logic signed [31:0] shifted_s;

  // Sum of lane products, kept at 33 bits so two full-scale products never wrap
  always_comb begin
    lane_a_s = 16'sd0;
    lane_b_s = 16'sd0;
    prod_s   = 32'sd0;
    sum_s    = 33'sd0;
    for (int i = 0; i < int'(NB_LANES); i++) begin
      lane_a_s = op_a[16*i +: 16];
      lane_b_s = op_b[16*i +: 16];
      prod_s   = lane_a_s * lane_b_s;
      sum_s    = sum_s + {prod_s[31], prod_s};
    end
  end

  assign shifted_s = 32'(sum_s >>> DOTP_SHIFT);
  assign result    = acc + shifted_s;

endmodule

// File: rtl/fir_xifu_ex.sv
// FIR XIFU execute stage: issues XFIRLW/XFIRSW memory requests, computes
// XFIRDOTP and feeds the ex2wb pipeline register under WB back-pressure.
module fir_xifu_ex
  import fir_xifu_pkg::*;
#(
  parameter int unsigned NB_LANES   = 2,
  parameter int unsigned DOTP_SHIFT = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  cv32e40x_if_xif.coproc_mem        xif_mem_o,
  input  id2ex_t                    id2ex_i,
  output ex2wb_t                    ex2wb_o,
  input  ctrl2ex_t                  ctrl2ex_i,
  input  wb_fwd_t                   wb_fwd_i,
  input  logic                      ready_i,
  output logic                      ready_o,
  output logic                      kill_o
);

  ex_state_e             state_r, state_n;
  logic                  mem_valid_r, mem_valid_n;
  xif_mem_req_t          mem_req_r, mem_req_n;
  ex2wb_t                pend_r, pend_n;
  ex2wb_t                ex2wb_r, ex2wb_n;
  logic                  kill_seen_r, kill_seen_n;

  logic                  fwd_hit_s;
  logic [31:0]           base_s;
  logic [31:0]           addr_s;
  logic [31:0]           next_addr_s;
  logic [31:0]           dotp_result_s;
  logic                  accept_s;
  logic [X_ID_WIDTH-1:0] cur_id_s;

  fir_xifu_dotp #(
    .NB_LANES   (NB_LANES),
    .DOTP_SHIFT (DOTP_SHIFT)
  ) u_dotp (
    .op_a   (id2ex_i.op_a),
    .op_b   (id2ex_i.op_b),
    .acc    (id2ex_i.acc),
    .result (dotp_result_s)
  );

  // A WB write to x0 never forwards; x0 always reads as the core-supplied value
  assign fwd_hit_s   = wb_fwd_i.we && (wb_fwd_i.rd == id2ex_i.rs1_addr) &&
                       (id2ex_i.rs1_addr != 5'd0);
  assign base_s      = fwd_hit_s ? wb_fwd_i.result : id2ex_i.rs1_cv;
  assign addr_s      = base_s + sext_imm(id2ex_i.imm);
  assign next_addr_s = base_s + 32'd4;

  assign ready_o  = ready_i && (state_r == EX_IDLE);
  assign accept_s = id2ex_i.valid && ready_o;
  assign cur_id_s = (state_r == EX_IDLE) ? id2ex_i.id : pend_r.id;
  assign kill_o   = (state_r == EX_IDLE) ? (id2ex_i.valid && ctrl2ex_i.kill[cur_id_s])
                                         : ctrl2ex_i.kill[cur_id_s];

  assign xif_mem_o.mem_valid = mem_valid_r;
  assign xif_mem_o.mem_req   = mem_req_r;
  assign ex2wb_o             = ex2wb_r;

  // Next-state and pipeline-register load logic
  always_comb begin
    state_n     = state_r;
    mem_valid_n = mem_valid_r;
    mem_req_n   = mem_req_r;
    pend_n      = pend_r;
    kill_seen_n = kill_seen_r;
    ex2wb_n     = ex2wb_r;
    case (state_r)
      EX_IDLE: begin
        if (accept_s && !kill_o) begin
          case (id2ex_i.instr)
            INSTR_XFIRDOTP: begin
              ex2wb_n = '{id: id2ex_i.id, instr: INSTR_XFIRDOTP, rd: id2ex_i.rd,
                          result: dotp_result_s, next_addr: 32'd0};
            end
            INSTR_XFIRLW, INSTR_XFIRSW: begin
              ex2wb_n     = EX2WB_BUBBLE;
              state_n     = EX_REQ;
              mem_valid_n = 1'b1;
              kill_seen_n = 1'b0;
              mem_req_n   = '{id: id2ex_i.id, addr: addr_s, mode: 2'b00,
                              we: (id2ex_i.instr == INSTR_XFIRSW), size: 3'b010,
                              be: 4'hF, attr: 2'b00,
                              wdata: (id2ex_i.instr == INSTR_XFIRSW) ? id2ex_i.op_b : 32'd0};
              pend_n      = '{id: id2ex_i.id, instr: id2ex_i.instr, rd: id2ex_i.rd,
                              result: 32'd0, next_addr: next_addr_s};
            end
            default: begin
              ex2wb_n = EX2WB_BUBBLE;
            end
          endcase
        end else if (ready_i) begin
          ex2wb_n = EX2WB_BUBBLE;
        end else begin
          ex2wb_n = ex2wb_r;
        end
      end
      EX_REQ: begin
        // The request cannot be retracted; a kill is remembered and acted on at mem_ready
        kill_seen_n = kill_seen_r | kill_o;
        if (xif_mem_o.mem_ready) begin
          mem_valid_n = 1'b0;
          if (kill_seen_r || kill_o) begin
            state_n = EX_IDLE;
            ex2wb_n = ready_i ? EX2WB_BUBBLE : ex2wb_r;
          end else if (ready_i) begin
            state_n = EX_IDLE;
            ex2wb_n = pend_r;
          end else begin
            state_n = EX_DONE;
          end
        end else if (ready_i) begin
          ex2wb_n = EX2WB_BUBBLE;
        end else begin
          ex2wb_n = ex2wb_r;
        end
      end
      EX_DONE: begin
        if (kill_o) begin
          state_n = EX_IDLE;
          ex2wb_n = ready_i ? EX2WB_BUBBLE : ex2wb_r;
        end else if (ready_i) begin
          state_n = EX_IDLE;
          ex2wb_n = pend_r;
        end else begin
          state_n = EX_DONE;
        end
      end
      default: begin
        state_n     = EX_IDLE;
        mem_valid_n = 1'b0;
        ex2wb_n     = EX2WB_BUBBLE;
      end
    endcase
  end

  // State and output registers; mem_valid drops on reset without a clock edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= EX_IDLE;
      mem_valid_r <= 1'b0;
      mem_req_r   <= '0;
      pend_r      <= EX2WB_BUBBLE;
      ex2wb_r     <= EX2WB_BUBBLE;
      kill_seen_r <= 1'b0;
    end else begin
      state_r     <= state_n;
      mem_valid_r <= mem_valid_n;
      mem_req_r   <= mem_req_n;
      pend_r      <= pend_n;
      ex2wb_r     <= ex2wb_n;
      kill_seen_r <= kill_seen_n;
    end
  end

endmodule
